serial_adder: RTL
=================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: none; operand width fixed at 64 bits, slice width fixed at 8 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request an add; sampled only in IDLE.
REQ-005 enable  input  1  output gate; sampled with start; 0 forces result to zero.
REQ-006 A  input  64  addend; captured on accepted start.
REQ-007 B  input  64  addend; captured on accepted start.
REQ-008 busy  output  1  high in RUN and DONE.
REQ-009 done  output  1  one-cycle pulse; result valid.
REQ-010 Sum  output  64  registered A+B modulo 2^64, gated by captured enable.
REQ-011 OF  output  1  registered signed overflow, gated by captured enable.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-013 IDLE with start=1 at an edge SHALL latch A, B and enable into internal registers, clear the slice counter to 0, load the carry register with carry-in (REQ-027/028), and enter RUN.
REQ-014 Each RUN edge SHALL add slice [8c+7:8c] of the latched operands plus the carry register, write the 8-bit result into shadow slice c, store the carry-out, and increment c.
REQ-015 The RUN edge with c=7 SHALL enter DONE and load Sum/OF from the completed shadow result.
REQ-016 DONE SHALL assert done for exactly one cycle and SHALL return to IDLE on the next edge.
REQ-017 Latency SHALL be fixed: done is high in the 9th cycle after the start-sampling edge (edges 1..8 compute, DONE follows edge 8).
REQ-018 OF SHALL equal (A[63]==B[63]) AND (result[63]!=A[63]), using the latched operands.
REQ-019 The final carry out of bit 63 SHALL be discarded (wrap-around); it SHALL NOT affect OF.
REQ-020 Captured enable=0 SHALL load Sum=0 and OF=0, with timing and done unchanged.
REQ-021 start while busy=1 SHALL be ignored, with no effect on latched operands or timing.
REQ-022 start asserted in the DONE cycle SHALL be ignored; a new start is accepted from IDLE only.
REQ-023 Sum and OF SHALL hold their last values from DONE through IDLE and the next RUN, until the next DONE.
REQ-024 A and B changing after capture SHALL NOT affect the result.

Reset
REQ-025 rst_n=0 SHALL asynchronously force: state IDLE, busy=0, done=0, Sum=0, OF=0, and clear the counter, carry, shadow and latched-operand registers.
REQ-026 Reset asserted mid-RUN SHALL abort the operation; the first start after release SHALL complete normally with full latency.

Configuration
REQ-027 With macro SERIAL_ADDER_CIN_EN defined, an input port cin (1 bit) SHALL exist, be latched on accepted start, and seed the carry register, giving Sum=A+B+cin; OF uses the same formula on this result.
REQ-028 Without SERIAL_ADDER_CIN_EN, no cin port SHALL exist and the carry register SHALL be seeded with 0.

Verification
REQ-029 A=5, B=3, enable=1, start pulse -> busy for 9 cycles, done in 9th cycle, Sum=0x0000000000000008, OF=0.
REQ-030 A=0x7FFFFFFFFFFFFFFF, B=1 -> Sum=0x8000000000000000, OF=1; also A=B=0x8000000000000000 -> Sum=0, OF=1.
REQ-031 A=0xFFFFFFFFFFFFFFFF, B=1 -> Sum=0, OF=0 (carry ripples across all 8 slices, wraps).
REQ-032 A=5, B=3, enable=0 -> done pulses on the same cycle, Sum=0, OF=0; previous Sum held until that DONE.
REQ-033 rst_n pulled low on the 4th RUN cycle -> busy, done, Sum and OF go 0 immediately; after release, A=2, B=2 -> Sum=4.
REQ-034 start re-pulsed on RUN cycles 3 and DONE with different A/B -> ignored; result matches the first operands; SERIAL_ADDER_CIN_EN build with cin=1, A=B=0 -> Sum=1.

Source files
------------

// File: rtl/serial_adder.sv
// 64-bit adder that processes one 8-bit slice per clock: 8 RUN cycles, then a DONE pulse.
// Define SERIAL_ADDER_CIN_EN to add a latched carry-in port (cin); otherwise the carry seeds with 0.
module serial_adder (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        enable,
`ifdef SERIAL_ADDER_CIN_EN
   input  logic        cin,
`endif
   input  logic [63:0] A,
   input  logic [63:0] B,
   output logic        busy,
   output logic        done,
   output logic [63:0] Sum,
   output logic        OF
);

   // Handshake: start is accepted only while busy=0 (IDLE); done pulses for one
   // cycle when Sum/OF have just been updated, and Sum/OF hold until the next done.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_next_state;
   logic [63:0] r_a;
   logic [63:0] r_b;
   logic        r_en;
   logic [2:0]  r_cnt;
   logic        r_carry;
   logic [63:0] r_shadow;
   logic [63:0] r_sum;
   logic        r_of;
   logic        w_cin;
   logic        w_accept;
   logic        w_last;
   logic [5:0]  w_base;
   logic [7:0]  w_slice_a;
   logic [7:0]  w_slice_b;
   logic [8:0]  w_add;
   logic [63:0] w_result;
   logic        w_of;

`ifdef SERIAL_ADDER_CIN_EN
   assign w_cin = cin;
`else
   assign w_cin = 1'b0;
`endif

   assign w_accept  = (r_state == S_IDLE) && start;
   assign w_last    = (r_state == S_RUN) && (r_cnt == 3'd7);
   assign w_base    = {r_cnt, 3'b000};
   assign w_slice_a = r_a[w_base +: 8];
   assign w_slice_b = r_b[w_base +: 8];
   assign w_add     = {1'b0, w_slice_a} + {1'b0, w_slice_b} + {8'b0, r_carry};
   // Top slice is still combinational on the last edge, so splice it onto the shadow.
   assign w_result  = {w_add[7:0], r_shadow[55:0]};
   assign w_of      = (r_a[63] == r_b[63]) && (w_result[63] != r_a[63]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next_state = S_RUN;
         S_RUN:   if (r_cnt == 3'd7) w_next_state = S_DONE;
         S_DONE:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (r_state)
         S_RUN:   busy = 1'b1;
         S_DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: begin
            busy = 1'b0;
            done = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a      <= 64'd0;
         r_b      <= 64'd0;
         r_en     <= 1'b0;
         r_cnt    <= 3'd0;
         r_carry  <= 1'b0;
         r_shadow <= 64'd0;
      end else if (w_accept) begin
         r_a      <= A;
         r_b      <= B;
         r_en     <= enable;
         r_cnt    <= 3'd0;
         r_carry  <= w_cin;
      end else if (r_state == S_RUN) begin
         r_shadow[w_base +: 8] <= w_add[7:0];
         r_carry               <= w_add[8];
         r_cnt                 <= r_cnt + 3'd1;
      end
   end

   // Final carry out of bit 63 is dropped; only the sign bits decide OF.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sum <= 64'd0;
         r_of  <= 1'b0;
      end else if (w_last) begin
         r_sum <= r_en ? w_result : 64'd0;
         r_of  <= r_en & w_of;
      end
   end

   assign Sum = r_sum;
   assign OF  = r_of;

endmodule
